// File: rtl/wash_cycle_sequencer.sv
// wash_cycle_sequencer
// Runs the laundry cycle picked by the program-selection FSM. It latches the
// program on start and walks through FILL / WASH / DRAIN / RINSE / SPIN / DRY.
// Valve, pump, motor and heater are driven from the current phase. Phase
// lengths come from a prescaled tick counter; FILL and DRAIN are bounded by
// sensor timeouts.
// Optional build macro PAUSE_EN: opening the door while busy parks the cycle
// in PAUSE, with timers frozen, instead of raising a door fault.
module wash_cycle_sequencer #(
  parameter int TICK_DIV = 1000,
  parameter int WASH_T   = 20,
  parameter int RINSE_T  = 10,
  parameter int SPIN_T   = 15,
  parameter int DRY_T    = 30,
  parameter int FILL_TO  = 40,
  parameter int DRAIN_TO = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] prog,
  input  logic       start,
  input  logic       abort,
  input  logic       door_closed,
  input  logic       water_full,
  input  logic       water_empty,
  input  logic       fault_clr,
  output logic       valve,
  output logic       pump,
  output logic       motor_wash,
  output logic       motor_spin,
  output logic       heater,
  output logic [3:0] phase,
  output logic       busy,
  output logic       done,
  output logic [1:0] fault_code
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FILL  = 4'd1;
  localparam logic [3:0] ST_WASH  = 4'd2;
  localparam logic [3:0] ST_DRAIN = 4'd3;
  localparam logic [3:0] ST_RINSE = 4'd4;
  localparam logic [3:0] ST_SPIN  = 4'd5;
  localparam logic [3:0] ST_DRY   = 4'd6;
  localparam logic [3:0] ST_DONE  = 4'd7;
  localparam logic [3:0] ST_FAULT = 4'd8;
`ifdef PAUSE_EN
  localparam logic [3:0] ST_PAUSE = 4'd9;
`endif

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_FILL  = 2'd1;
  localparam logic [1:0] FC_DRAIN = 2'd2;
  localparam logic [1:0] FC_DOOR  = 2'd3;

  // Timer operations selected each cycle by the sequencing logic
  localparam logic [1:0] TMR_RUN  = 2'd0;
  localparam logic [1:0] TMR_CLR  = 2'd1;
  localparam logic [1:0] TMR_HOLD = 2'd2;

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  // Programs accepted on start: drying, economy, normal, heavy
  function automatic logic prog_ok(input logic [2:0] p);
    logic ok;
    case (p)
      3'b001, 3'b010, 3'b011, 3'b100: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Wash intensity and rinse count share the same 1/2/3 grading
  function automatic logic [1:0] lvl_of(input logic [2:0] p);
    logic [1:0] l;
    case (p)
      3'b010:  l = 2'd1;
      3'b011:  l = 2'd2;
      3'b100:  l = 2'd3;
      default: l = 2'd0;
    endcase
    return l;
  endfunction

  // Actuator pattern {valve, pump, motor_wash, motor_spin, heater} per phase
  function automatic logic [4:0] act_of(input logic [3:0] st);
    logic [4:0] a;
    case (st)
      ST_FILL:  a = 5'b10000;
      ST_WASH:  a = 5'b00100;
      ST_DRAIN: a = 5'b01000;
      ST_RINSE: a = 5'b00100;
      ST_SPIN:  a = 5'b01010;
      ST_DRY:   a = 5'b00101;
      default:  a = 5'b00000;
    endcase
    return a;
  endfunction

  // Machine is busy everywhere except the resting states
  function automatic logic busy_of(input logic [3:0] st);
    logic b;
    case (st)
      ST_IDLE, ST_DONE, ST_FAULT: b = 1'b0;
      default:                    b = 1'b1;
    endcase
    return b;
  endfunction

  logic [3:0]  state_r;
  logic [3:0]  next_s;
  logic [2:0]  prog_r;
  logic [2:0]  prog_n_s;
  logic [1:0]  rinse_r;
  logic [1:0]  rinse_n_s;
  logic        aborted_r;
  logic        aborted_n_s;
  logic        rfill_r;
  logic        rfill_n_s;
  logic [1:0]  fault_n_s;
  logic [15:0] presc_r;
  logic [15:0] tick_r;
  logic [15:0] lim_s;
  logic        presc_end_s;
  logic        phase_end_s;
  logic        trip_s;
  logic        hold_tmr_s;
  logic        pause_in_s;
  logic [1:0]  tmr_op_s;
`ifdef PAUSE_EN
  logic [3:0]  saved_r;
  logic [3:0]  saved_n_s;
`endif

  assign phase = state_r;

  // Phase length in ticks for the current state; wash scales with intensity
  always_comb begin
    lim_s = 16'd0;
    case (state_r)
      ST_FILL:  lim_s = 16'(FILL_TO);
      ST_DRAIN: lim_s = 16'(DRAIN_TO);
      ST_RINSE: lim_s = 16'(RINSE_T);
      ST_SPIN:  lim_s = 16'(SPIN_T);
      ST_DRY:   lim_s = 16'(DRY_T);
      ST_WASH: begin
        case (lvl_of(prog_r))
          2'd2:    lim_s = 16'(2 * WASH_T);
          2'd3:    lim_s = 16'(3 * WASH_T);
          default: lim_s = 16'(WASH_T);
        endcase
      end
      default:  lim_s = 16'd0;
    endcase
  end

  // Phase ends on the last prescaler cycle of the last tick; the >= term
  // covers a phase paused exactly at its final cycle
  always_comb begin
    presc_end_s = (presc_r == PRESC_LAST);
    if (tick_r >= lim_s) begin
      phase_end_s = 1'b1;
    end else begin
      phase_end_s = (tick_r == (lim_s - 16'd1)) && presc_end_s;
    end
  end

  // Door opening is only relevant while actuators may be running
  always_comb begin
    case (state_r)
      ST_FILL, ST_WASH, ST_DRAIN, ST_RINSE, ST_SPIN, ST_DRY:
        trip_s = ~door_closed;
      default:
        trip_s = 1'b0;
    endcase
  end

  // Next-state, program latch, rinse bookkeeping and fault code selection
  always_comb begin
    next_s      = state_r;
    prog_n_s    = prog_r;
    rinse_n_s   = rinse_r;
    aborted_n_s = aborted_r;
    rfill_n_s   = rfill_r;
    fault_n_s   = fault_code;
    hold_tmr_s  = 1'b0;
    pause_in_s  = 1'b0;
`ifdef PAUSE_EN
    saved_n_s   = saved_r;
`endif
    if (trip_s) begin
`ifdef PAUSE_EN
      next_s     = ST_PAUSE;
      saved_n_s  = state_r;
      pause_in_s = 1'b1;
`else
      next_s     = ST_FAULT;
      fault_n_s  = FC_DOOR;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && door_closed && prog_ok(prog)) begin
            prog_n_s    = prog;
            rinse_n_s   = lvl_of(prog);
            aborted_n_s = 1'b0;
            rfill_n_s   = 1'b0;
            if (prog == 3'b001) begin
              next_s = ST_DRY;
            end else begin
              next_s = ST_FILL;
            end
          end else begin
            next_s = ST_IDLE;
          end
        end
        ST_FILL: begin
          if (abort) begin
            next_s      = ST_DRAIN;
            aborted_n_s = 1'b1;
            rinse_n_s   = 2'd0;
          end else if (water_full) begin
            if (rfill_r) begin
              next_s = ST_RINSE;
            end else begin
              next_s = ST_WASH;
            end
          end else if (phase_end_s) begin
            next_s    = ST_FAULT;
            fault_n_s = FC_FILL;
          end else begin
            next_s = ST_FILL;
          end
        end
        ST_WASH: begin
          if (abort) begin
            next_s      = ST_DRAIN;
            aborted_n_s = 1'b1;
            rinse_n_s   = 2'd0;
          end else if (phase_end_s) begin
            next_s = ST_DRAIN;
          end else begin
            next_s = ST_WASH;
          end
        end
        ST_DRAIN: begin
          if (water_empty) begin
            if (aborted_r) begin
              next_s = ST_IDLE;
            end else if (rinse_r != 2'd0) begin
              next_s    = ST_FILL;
              rfill_n_s = 1'b1;
            end else begin
              next_s = ST_SPIN;
            end
          end else if (phase_end_s) begin
            next_s    = ST_FAULT;
            fault_n_s = FC_DRAIN;
          end else begin
            next_s = ST_DRAIN;
          end
        end
        ST_RINSE: begin
          if (abort) begin
            next_s      = ST_DRAIN;
            aborted_n_s = 1'b1;
            rinse_n_s   = 2'd0;
          end else if (phase_end_s) begin
            next_s = ST_DRAIN;
            if (rinse_r != 2'd0) begin
              rinse_n_s = rinse_r - 2'd1;
            end else begin
              rinse_n_s = 2'd0;
            end
          end else begin
            next_s = ST_RINSE;
          end
        end
        ST_SPIN: begin
          if (abort) begin
            next_s      = ST_DRAIN;
            aborted_n_s = 1'b1;
            rinse_n_s   = 2'd0;
          end else if (phase_end_s) begin
            next_s = ST_DONE;
          end else begin
            next_s = ST_SPIN;
          end
        end
        ST_DRY: begin
          if (abort) begin
            next_s = ST_IDLE;
          end else if (phase_end_s) begin
            next_s = ST_DONE;
          end else begin
            next_s = ST_DRY;
          end
        end
        ST_DONE: begin
          next_s = ST_IDLE;
        end
        ST_FAULT: begin
          if (fault_clr) begin
            next_s    = ST_IDLE;
            fault_n_s = FC_NONE;
          end else begin
            next_s = ST_FAULT;
          end
        end
`ifdef PAUSE_EN
        ST_PAUSE: begin
          if (abort) begin
            next_s      = ST_DRAIN;
            aborted_n_s = 1'b1;
            rinse_n_s   = 2'd0;
          end else if (start && door_closed) begin
            next_s     = saved_r;
            hold_tmr_s = 1'b1;
          end else begin
            next_s     = ST_PAUSE;
            hold_tmr_s = 1'b1;
          end
        end
`endif
        default: begin
          next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Timers restart on every state entry, except entering/leaving a pause,
  // which keeps the remaining time
  always_comb begin
    if (hold_tmr_s) begin
      tmr_op_s = TMR_HOLD;
    end else if ((next_s != state_r) && !pause_in_s) begin
      tmr_op_s = TMR_CLR;
    end else begin
      tmr_op_s = TMR_RUN;
    end
  end

  // Prescaler and saturating tick counter
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= 16'd0;
      tick_r  <= 16'd0;
    end else begin
      case (tmr_op_s)
        TMR_CLR: begin
          presc_r <= 16'd0;
          tick_r  <= 16'd0;
        end
        TMR_HOLD: begin
          presc_r <= presc_r;
          tick_r  <= tick_r;
        end
        TMR_RUN: begin
          if (presc_end_s) begin
            presc_r <= 16'd0;
            if (tick_r != 16'hFFFF) begin
              tick_r <= tick_r + 16'd1;
            end else begin
              tick_r <= tick_r;
            end
          end else begin
            presc_r <= presc_r + 16'd1;
          end
        end
        default: begin
          presc_r <= 16'd0;
          tick_r  <= 16'd0;
        end
      endcase
    end
  end

  // Sequencer state and cycle context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      prog_r    <= 3'b000;
      rinse_r   <= 2'd0;
      aborted_r <= 1'b0;
      rfill_r   <= 1'b0;
    end else begin
      state_r   <= next_s;
      prog_r    <= prog_n_s;
      rinse_r   <= rinse_n_s;
      aborted_r <= aborted_n_s;
      rfill_r   <= rfill_n_s;
    end
  end

`ifdef PAUSE_EN
  // Phase to return to after a pause
  always_ff @(posedge clk) begin
    if (rst) begin
      saved_r <= ST_IDLE;
    end else begin
      saved_r <= saved_n_s;
    end
  end
`endif

  // Registered outputs decoded from the state being entered, so they line
  // up with phase on every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      {valve, pump, motor_wash, motor_spin, heater} <= 5'b00000;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      {valve, pump, motor_wash, motor_spin, heater} <= act_of(next_s);
      busy       <= busy_of(next_s);
      done       <= (next_s == ST_DONE);
      fault_code <= fault_n_s;
    end
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Self-checking bench for wash_cycle_sequencer. A monitor splits the phase
// output into segments and checks each one against a queue of expected
// {phase, length} entries that each scenario pushes before it starts.
module tb_wash_cycle_sequencer;

  localparam logic [3:0] PH_IDLE  = 4'd0;
  localparam logic [3:0] PH_FILL  = 4'd1;
  localparam logic [3:0] PH_WASH  = 4'd2;
  localparam logic [3:0] PH_DRAIN = 4'd3;
  localparam logic [3:0] PH_RINSE = 4'd4;
  localparam logic [3:0] PH_SPIN  = 4'd5;
  localparam logic [3:0] PH_DRY   = 4'd6;
  localparam logic [3:0] PH_DONE  = 4'd7;
  localparam logic [3:0] PH_FAULT = 4'd8;
  localparam logic [3:0] PH_PAUSE = 4'd9;

  logic       clk;
  logic       rst;
  logic [2:0] prog;
  logic       start;
  logic       abort;
  logic       door_closed;
  logic       water_full;
  logic       water_empty;
  logic       fault_clr;
  logic       valve;
  logic       pump;
  logic       motor_wash;
  logic       motor_spin;
  logic       heater;
  logic [3:0] phase;
  logic       busy;
  logic       done;
  logic [1:0] fault_code;

  typedef struct {
    logic [3:0] ph;
    int         len;   // 0 = length not checked
  } seg_t;

  seg_t q[$];
  int   n_tests;
  int   n_fail;
  int   fill_dly;
  int   drain_dly;
  bit   mon_en;

  wash_cycle_sequencer #(
    .TICK_DIV(4), .WASH_T(3), .RINSE_T(2), .SPIN_T(2),
    .DRY_T(5), .FILL_TO(6), .DRAIN_TO(6)
  ) dut (
    .clk(clk), .rst(rst), .prog(prog), .start(start), .abort(abort),
    .door_closed(door_closed), .water_full(water_full),
    .water_empty(water_empty), .fault_clr(fault_clr), .valve(valve),
    .pump(pump), .motor_wash(motor_wash), .motor_spin(motor_spin),
    .heater(heater), .phase(phase), .busy(busy), .done(done),
    .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] act_vec();
    return {valve, pump, motor_wash, motor_spin, heater, busy, done};
  endfunction

  // {valve,pump,motor_wash,motor_spin,heater,busy,done} required in each phase
  function automatic logic [6:0] exp_act(input logic [3:0] ph);
    case (ph)
      PH_FILL:  return 7'b1000010;
      PH_WASH:  return 7'b0010010;
      PH_DRAIN: return 7'b0100010;
      PH_RINSE: return 7'b0010010;
      PH_SPIN:  return 7'b0101010;
      PH_DRY:   return 7'b0010110;
      PH_DONE:  return 7'b0000001;
      PH_PAUSE: return 7'b0000010;
      default:  return 7'b0000000;
    endcase
  endfunction

  task automatic push_seg(input logic [3:0] ph, input int len);
    seg_t s;
    s.ph  = ph;
    s.len = len;
    q.push_back(s);
  endtask

  task automatic kick(input logic [2:0] p);
    @(negedge clk);
    prog  = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_phase(input logic [3:0] ph, input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((phase != ph) && (n < budget));
    chk_eq(tag, int'(phase), int'(ph));
  endtask

  task automatic finish_scn(input string tag);
    wait_phase(PH_IDLE, 400, {tag, "_idle"});
    repeat (2) @(negedge clk);
    chk_eq({tag, "_sb_empty"}, q.size(), 0);
    q.delete();
  endtask

  // Sensor model: level sensors answer a set number of cycles into FILL/DRAIN
  initial begin
    int fc;
    int dc;
    fc = 0;
    dc = 0;
    water_full  = 1'b0;
    water_empty = 1'b0;
    forever begin
      @(negedge clk);
      if (phase == PH_FILL) fc++; else fc = 0;
      if (phase == PH_DRAIN) dc++; else dc = 0;
      water_full  = (fc >= fill_dly);
      water_empty = (dc >= drain_dly);
    end
  end

  // Monitor: pops one expected segment each time a non-IDLE phase ends
  initial begin
    logic [3:0] cur;
    int         run;
    int         bad;
    seg_t       e;
    cur = PH_IDLE;
    run = 0;
    bad = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (phase == cur) begin
          run++;
        end else begin
          if (cur != PH_IDLE) begin
            if (q.size() == 0) begin
              chk_eq("seg_unexpected", q.size(), 1);
            end else begin
              e = q.pop_front();
              chk_eq("seg_phase", int'(cur), int'(e.ph));
              if (e.len != 0) chk_eq("seg_len", run, e.len);
              chk_eq("seg_outputs_bad", bad, 0);
            end
          end
          cur = phase;
          run = 1;
          bad = 0;
        end
        if ((cur != PH_IDLE) && (act_vec() != exp_act(cur))) bad = 1;
      end
    end
  end

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    fill_dly    = 3;
    drain_dly   = 3;
    mon_en      = 1'b0;
    rst         = 1'b1;
    prog        = 3'b000;
    start       = 1'b0;
    abort       = 1'b0;
    door_closed = 1'b1;
    fault_clr   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_eq("rst_phase", int'(phase), int'(PH_IDLE));
    chk_eq("rst_outputs", int'(act_vec()), 0);
    chk_eq("rst_fault_code", int'(fault_code), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Drying: DRY 5 ticks * 4 = 20 cycles, then done pulse
    push_seg(PH_DRY, 20);
    push_seg(PH_DONE, 1);
    kick(3'b001);
    finish_scn("dry");

    // Normal: wash 3*2*4 = 24, two rinses of 8, spin 8
    push_seg(PH_FILL, 3);  push_seg(PH_WASH, 24); push_seg(PH_DRAIN, 3);
    push_seg(PH_FILL, 3);  push_seg(PH_RINSE, 8); push_seg(PH_DRAIN, 3);
    push_seg(PH_FILL, 3);  push_seg(PH_RINSE, 8); push_seg(PH_DRAIN, 3);
    push_seg(PH_SPIN, 8);  push_seg(PH_DONE, 1);
    kick(3'b011);
    finish_scn("normal");

    // Heavy with no water: fill timeout after 6*4 = 24 cycles
    fill_dly = 1000;
    push_seg(PH_FILL, 24);
    push_seg(PH_FAULT, 0);
    kick(3'b100);
    wait_phase(PH_FAULT, 100, "filltmo_fault");
    chk_eq("filltmo_code", int'(fault_code), 1);
    chk_eq("filltmo_valve", int'(valve), 0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk_eq("filltmo_clr_phase", int'(phase), int'(PH_IDLE));
    chk_eq("filltmo_clr_code", int'(fault_code), 0);
    fill_dly = 3;
    finish_scn("filltmo");

    // Economy aborted after 5 wash cycles: drain then idle, no spin/done
    push_seg(PH_FILL, 3); push_seg(PH_WASH, 5); push_seg(PH_DRAIN, 3);
    kick(3'b010);
    wait_phase(PH_WASH, 50, "abort_wash");
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    finish_scn("abort");

    // Door opens mid-wash with abort high in the same cycle
`ifdef PAUSE_EN
    push_seg(PH_FILL, 3);  push_seg(PH_WASH, 4);  push_seg(PH_PAUSE, 0);
    push_seg(PH_WASH, 8);  push_seg(PH_DRAIN, 3); push_seg(PH_FILL, 3);
    push_seg(PH_RINSE, 8); push_seg(PH_DRAIN, 3); push_seg(PH_SPIN, 8);
    push_seg(PH_DONE, 1);
`else
    push_seg(PH_FILL, 3); push_seg(PH_WASH, 4); push_seg(PH_FAULT, 0);
`endif
    kick(3'b010);
    wait_phase(PH_WASH, 50, "door_wash");
    repeat (3) @(negedge clk);
    door_closed = 1'b0;
    abort       = 1'b1;
    @(negedge clk);
    door_closed = 1'b1;
    abort       = 1'b0;
`ifdef PAUSE_EN
    chk_eq("door_pause", int'(phase), int'(PH_PAUSE));
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`else
    chk_eq("door_fault", int'(phase), int'(PH_FAULT));
    chk_eq("door_code", int'(fault_code), 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_eq("door_start_ignored", int'(phase), int'(PH_FAULT));
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
`endif
    finish_scn("door");

    // Invalid programs and an open door never leave IDLE
    kick(3'b110);
    repeat (2) @(negedge clk);
    chk_eq("inv110_phase", int'(phase), int'(PH_IDLE));
    chk_eq("inv110_busy", int'(busy), 0);
    kick(3'b000);
    repeat (2) @(negedge clk);
    chk_eq("inv000_phase", int'(phase), int'(PH_IDLE));
    door_closed = 1'b0;
    kick(3'b011);
    repeat (2) @(negedge clk);
    chk_eq("dooropen_start_phase", int'(phase), int'(PH_IDLE));
    door_closed = 1'b1;
    @(negedge clk);

    // Reset in the middle of SPIN
    push_seg(PH_FILL, 3); push_seg(PH_WASH, 12); push_seg(PH_DRAIN, 3);
    push_seg(PH_FILL, 3); push_seg(PH_RINSE, 8); push_seg(PH_DRAIN, 3);
    push_seg(PH_SPIN, 0);
    kick(3'b010);
    wait_phase(PH_SPIN, 200, "rst_spin");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("midrst_phase", int'(phase), int'(PH_IDLE));
    chk_eq("midrst_outputs", int'(act_vec()), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("midrst_sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
